// File: rtl/main_mem_ctrl.sv
// Word-array memory controller: fixed-latency read FSM plus a posted-write FIFO drained into the array.
// Optional macro MEM_WB_FWD_EN forwards buffered write data to reads; without it, reads that hit the buffer wait for the drain.
module main_mem_ctrl #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADD_WIDTH    = 12,
  parameter int READ_LATENCY = 3,
  parameter int WB_DEPTH     = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  mem_rd_en,
  input  logic [ADD_WIDTH-1:0]  mem_rd_addr,
  input  logic                  mem_wr_en,
  input  logic [ADD_WIDTH-1:0]  mem_wr_addr,
  input  logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  mem_rd_valid,
  output logic                  mem_busy,
  output logic                  mem_wr_full,
  output logic                  err_overflow
);

  localparam int PTR_W = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
  localparam int CNT_W = $clog2(WB_DEPTH) + 1;
  localparam logic [3:0] CNT_LOAD = 4'(READ_LATENCY - 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [ADD_WIDTH-1:0]  addr;
    logic [DATA_WIDTH-1:0] data;
  } wb_entry_t;

  logic [DATA_WIDTH-1:0] mem_array [2**ADD_WIDTH];
  wb_entry_t             wb_mem    [WB_DEPTH];

  state_t                state;
  logic [3:0]            lat_cnt;
  logic [ADD_WIDTH-1:0]  rd_addr_q;

  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      wb_count;

  logic                  drain;
  logic                  wr_accept;
  logic                  wb_hit;
  logic                  wait_stall;
  logic [DATA_WIDTH-1:0] resp_data;
  wb_entry_t             wb_head;
`ifdef MEM_WB_FWD_EN
  logic [DATA_WIDTH-1:0] fwd_data;
`endif

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(WB_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // The array has a single port: the RESP cycle owns it for the read, so draining pauses there.
  assign drain       = !reset && (wb_count != '0) && (state != RESP);
  assign mem_wr_full = (wb_count == CNT_W'(WB_DEPTH));
  assign wr_accept   = !reset && mem_wr_en && (!mem_wr_full || drain);
  assign wb_head     = wb_mem[rd_ptr];

  // Scan oldest to newest so the last match wins, giving the newest buffered value.
  always_comb begin
    wb_hit = 1'b0;
`ifdef MEM_WB_FWD_EN
    fwd_data = '0;
`endif
    for (int k = 0; k < WB_DEPTH; k++) begin
      if ((CNT_W'(k) < wb_count) &&
          (wb_mem[PTR_W'((int'(rd_ptr) + k) % WB_DEPTH)].addr == rd_addr_q)) begin
        wb_hit = 1'b1;
`ifdef MEM_WB_FWD_EN
        fwd_data = wb_mem[PTR_W'((int'(rd_ptr) + k) % WB_DEPTH)].data;
`endif
      end
    end
  end

`ifdef MEM_WB_FWD_EN
  assign resp_data  = wb_hit ? fwd_data : mem_array[rd_addr_q];
  assign wait_stall = 1'b0;
`else
  assign resp_data  = mem_array[rd_addr_q];
  assign wait_stall = wb_hit;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      lat_cnt      <= '0;
      rd_addr_q    <= '0;
      mem_rd_data  <= '0;
      mem_rd_valid <= 1'b0;
      mem_busy     <= 1'b0;
    end else begin
      mem_rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_rd_en) begin
            state     <= WAIT;
            rd_addr_q <= mem_rd_addr;
            lat_cnt   <= CNT_LOAD;
            mem_busy  <= 1'b1;
          end
        end
        WAIT: begin
          if (lat_cnt != '0) begin
            lat_cnt <= lat_cnt - 4'd1;
          end else if (!wait_stall) begin
            state <= RESP;
          end
        end
        RESP: begin
          mem_rd_data  <= resp_data;
          mem_rd_valid <= 1'b1;
          mem_busy     <= 1'b0;
          state        <= IDLE;
        end
        default: begin
          state    <= IDLE;
          mem_busy <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      wb_count     <= '0;
      err_overflow <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (drain) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({wr_accept, drain})
        2'b10:   wb_count <= wb_count + CNT_W'(1);
        2'b01:   wb_count <= wb_count - CNT_W'(1);
        default: wb_count <= wb_count;
      endcase
      if (mem_wr_en && !wr_accept) begin
        err_overflow <= 1'b1;
      end
    end
  end

  // Storage only: no reset, so array contents survive reset and stale buffer slots are harmless.
  always_ff @(posedge clock) begin
    if (wr_accept) begin
      wb_mem[wr_ptr] <= '{addr: mem_wr_addr, data: mem_wr_data};
    end
    if (drain) begin
      mem_array[wb_head.addr] <= wb_head.data;
    end
  end

endmodule

// File: tb/tb_main_mem_ctrl.sv
// Scoreboard bench for main_mem_ctrl: read expectations are queued at issue, a negedge monitor checks data and latency.
module tb_main_mem_ctrl;

`ifdef MEM_WB_FWD_EN
  localparam int HIT_LAT = 3;
`else
  localparam int HIT_LAT = 5;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mem_rd_en = 1'b0;
  logic [11:0] mem_rd_addr = '0;
  logic        mem_wr_en = 1'b0;
  logic [11:0] mem_wr_addr = '0;
  logic [31:0] mem_wr_data = '0;
  logic [31:0] mem_rd_data;
  logic        mem_rd_valid;
  logic        mem_busy;
  logic        mem_wr_full;
  logic        err_overflow;

  always #5 clock = ~clock;

  main_mem_ctrl #(
    .DATA_WIDTH  (32),
    .ADD_WIDTH   (12),
    .READ_LATENCY(3),
    .WB_DEPTH    (4)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data),
    .mem_rd_data (mem_rd_data),
    .mem_rd_valid(mem_rd_valid),
    .mem_busy    (mem_busy),
    .mem_wr_full (mem_wr_full),
    .err_overflow(err_overflow)
  );

  typedef struct {
    logic [31:0] data;
    int          issue;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc_n  = 0;

  always @(posedge clock) cyc_n <= cyc_n + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (!reset && mem_rd_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rd_valid: got valid=1 data=0x%0h expected no pending read", mem_rd_data);
      end else begin
        e = exp_q.pop_front();
        check("rd_data", mem_rd_data, e.data);
        check("rd_latency", 32'(cyc_n - e.issue), 32'(e.lat));
      end
    end
  end

  task automatic drive(input logic rd, input logic [11:0] ra, input logic wr,
                       input logic [11:0] wa, input logic [31:0] wd);
    mem_rd_en   = rd;
    mem_rd_addr = ra;
    mem_wr_en   = wr;
    mem_wr_addr = wa;
    mem_wr_data = wd;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 12'h0, 1'b0, 12'h0, 32'h0);
    repeat (n) tick();
  endtask

  task automatic expect_rd(input logic [31:0] d, input int lat);
    exp_q.push_back('{data: d, issue: cyc_n, lat: lat});
  endtask

  task automatic wait_resp();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout: got %0d reads outstanding expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic preload(input logic [11:0] a, input logic [31:0] d);
    drive(1'b0, 12'h0, 1'b1, a, d);
    tick();
  endtask

  task automatic read_single(input logic [11:0] a, input logic [31:0] d, input int lat);
    drive(1'b1, a, 1'b0, 12'h0, 32'h0);
    tick();
    expect_rd(d, lat);
    drive(1'b0, 12'h0, 1'b0, 12'h0, 32'h0);
    wait_resp();
    idle(1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200us");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    reset = 1'b1;
    idle(3);
    check("rst_valid", 32'(mem_rd_valid), 32'h0);
    check("rst_busy", 32'(mem_busy), 32'h0);
    check("rst_full", 32'(mem_wr_full), 32'h0);
    check("rst_err", 32'(err_overflow), 32'h0);
    check("rst_data", mem_rd_data, 32'h0);
    reset = 1'b0;
    idle(2);

    preload(12'h010, 32'hCAFE0001);
    preload(12'h100, 32'h01000100);
    preload(12'h20F, 32'hDEAD000F);
    preload(12'h0FF, 32'h00000005);
    preload(12'h300, 32'h33330000);
    preload(12'h301, 32'h33330001);
    idle(3);

    // Basic read: busy for three cycles, valid exactly three edges after acceptance
    drive(1'b1, 12'h010, 1'b0, 12'h0, 32'h0);
    tick();
    expect_rd(32'hCAFE0001, 3);
    drive(1'b0, 12'h0, 1'b0, 12'h0, 32'h0);
    check("busy_c1", 32'(mem_busy), 32'h1);
    tick();
    check("busy_c2", 32'(mem_busy), 32'h1);
    check("valid_c2", 32'(mem_rd_valid), 32'h0);
    tick();
    check("busy_c3", 32'(mem_busy), 32'h1);
    check("valid_c3", 32'(mem_rd_valid), 32'h0);
    tick();
    check("busy_c4", 32'(mem_busy), 32'h0);
    check("valid_c4", 32'(mem_rd_valid), 32'h1);
    tick();
    check("valid_c5", 32'(mem_rd_valid), 32'h0);
    idle(2);

    // Continuous reads with a write every cycle: only RESP edges grow the buffer
    for (int k = 0; k < 16; k++) begin
      drive(1'b1, 12'h100, 1'b1, 12'(12'h200 + k), 32'(32'hA0000000 + k));
      tick();
      if (k % 4 == 0) expect_rd(32'h01000100, 3);
      if (k == 3) check("ovf_busy_resp", 32'(mem_busy), 32'h0);
      if (k == 4) check("ovf_busy_wait", 32'(mem_busy), 32'h1);
      if (k == 10) check("full_before", 32'(mem_wr_full), 32'h0);
      if (k == 11) check("full_after4", 32'(mem_wr_full), 32'h1);
      if (k == 14) check("err_full_enq_deq", 32'(err_overflow), 32'h0);
      if (k == 15) begin
        check("err_drop", 32'(err_overflow), 32'h1);
        check("full_drop", 32'(mem_wr_full), 32'h1);
      end
    end

    // Back-to-back writes to 0x020 behind a full buffer, then a read of 0x020
    drive(1'b0, 12'h0, 1'b1, 12'h020, 32'h11111111);
    tick();
    check("full_keep1", 32'(mem_wr_full), 32'h1);
    drive(1'b0, 12'h0, 1'b1, 12'h020, 32'h22222222);
    tick();
    check("full_keep2", 32'(mem_wr_full), 32'h1);
    drive(1'b1, 12'h020, 1'b0, 12'h0, 32'h0);
    tick();
    expect_rd(32'h22222222, HIT_LAT);
    drive(1'b0, 12'h0, 1'b0, 12'h0, 32'h0);
    wait_resp();
    idle(4);
    check("full_drained", 32'(mem_wr_full), 32'h0);
    check("err_sticky", 32'(err_overflow), 32'h1);
    read_single(12'h20F, 32'hDEAD000F, 3);
    read_single(12'h20E, 32'hA000000E, 3);

    // Write landing on the RESP edge is not seen by that response
    drive(1'b1, 12'h0FF, 1'b0, 12'h0, 32'h0);
    tick();
    expect_rd(32'h00000005, 3);
    drive(1'b0, 12'h0, 1'b0, 12'h0, 32'h0);
    tick();
    tick();
    drive(1'b0, 12'h0, 1'b1, 12'h0FF, 32'h0000ABCD);
    tick();
    drive(1'b0, 12'h0, 1'b0, 12'h0, 32'h0);
    wait_resp();
    idle(2);
    read_single(12'h0FF, 32'h0000ABCD, 3);

    // Reset during WAIT with two writes still buffered
    check("err_before_rst", 32'(err_overflow), 32'h1);
    drive(1'b1, 12'h100, 1'b0, 12'h0, 32'h0);
    tick();
    expect_rd(32'h01000100, 3);
    tick();
    drive(1'b1, 12'h100, 1'b1, 12'h302, 32'h77770002);
    tick();
    drive(1'b1, 12'h100, 1'b1, 12'h300, 32'h77770000);
    tick();
    drive(1'b1, 12'h100, 1'b1, 12'h301, 32'h77770001);
    tick();
    check("busy_pre_rst", 32'(mem_busy), 32'h1);
    reset = 1'b1;
    drive(1'b0, 12'h0, 1'b0, 12'h0, 32'h0);
    tick();
    check("mid_rst_valid", 32'(mem_rd_valid), 32'h0);
    check("mid_rst_busy", 32'(mem_busy), 32'h0);
    check("mid_rst_full", 32'(mem_wr_full), 32'h0);
    check("mid_rst_err", 32'(err_overflow), 32'h0);
    reset = 1'b0;
    idle(6);
    check("queue_empty_post_rst", 32'(exp_q.size()), 32'h0);
    read_single(12'h300, 32'h33330000, 3);
    read_single(12'h301, 32'h33330001, 3);
    read_single(12'h302, 32'h77770002, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
